// File: rtl/csr_pkg.sv
// Shared encodings for the machine-mode CSR file: operation enum, CSR addresses,
// mstatus field positions and trap cause codes.
package csr_pkg;

  typedef enum logic [1:0] {
    CSR_NONE = 2'b00,
    CSR_RW   = 2'b01,
    CSR_RS   = 2'b10,
    CSR_RC   = 2'b11
  } csr_op_e;

  localparam logic [11:0] ADDR_MSTATUS   = 12'h300;
  localparam logic [11:0] ADDR_MISA      = 12'h301;
  localparam logic [11:0] ADDR_MTVEC     = 12'h305;
  localparam logic [11:0] ADDR_MSCRATCH  = 12'h340;
  localparam logic [11:0] ADDR_MEPC      = 12'h341;
  localparam logic [11:0] ADDR_MCAUSE    = 12'h342;
  localparam logic [11:0] ADDR_MCYCLE    = 12'hB00;
  localparam logic [11:0] ADDR_MCYCLEH   = 12'hB80;
  localparam logic [11:0] ADDR_MINSTRET  = 12'hB02;
  localparam logic [11:0] ADDR_MINSTRETH = 12'hB82;
  localparam logic [11:0] ADDR_MVENDORID = 12'hF11;
  localparam logic [11:0] ADDR_MARCHID   = 12'hF12;

  localparam int MSTATUS_MIE    = 3;
  localparam int MSTATUS_MPIE   = 7;
  localparam int MSTATUS_MPP_LO = 11;
  localparam int MSTATUS_MPP_HI = 12;

  localparam int          MCAUSE_ECALL_M = 11;
  localparam logic [31:0] MISA_RV32I     = 32'h4000_0100;

endpackage

// File: rtl/csr_counter.sv
// Free-running CSR counter with half-word write ports; a write to either half
// replaces that half and suppresses the increment for that cycle.
module csr_counter #(
  parameter int XLEN      = 32,
  parameter int CNT_WIDTH = 64
) (
  input  logic                 clock,
  input  logic                 reset,
  input  logic                 inc,
  input  logic                 wr_lo,
  input  logic                 wr_hi,
  input  logic [XLEN-1:0]      wdata,
  output logic [CNT_WIDTH-1:0] value
);

  logic [CNT_WIDTH-1:0] value_reg;
  logic [CNT_WIDTH-1:0] value_next;
  logic [CNT_WIDTH-1:0] merged;

  generate
    if (CNT_WIDTH > XLEN) begin : g_wide
      assign merged = {wr_hi ? wdata : value_reg[CNT_WIDTH-1:XLEN],
                       wr_lo ? wdata : value_reg[XLEN-1:0]};
    end else begin : g_narrow
      assign merged = wr_lo ? wdata : value_reg;
    end
  endgenerate

  always_comb begin
    value_next = value_reg;
    if (wr_lo || wr_hi) begin
      value_next = merged;
    end else if (inc) begin
      value_next = value_reg + CNT_WIDTH'(1);
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      value_reg <= '0;
    end else begin
      value_reg <= value_next;
    end
  end

  assign value = value_reg;

endmodule

// File: rtl/csr_machine_file.sv
// Machine-mode CSR file: CSRRW/RS/RC access, ecall/mret trap sequencing with
// mstatus interrupt-enable stacking, and mcycle/minstret counters.
module csr_machine_file
  import csr_pkg::*;
#(
  parameter int              XLEN          = 32,
  parameter int              CNT_WIDTH     = 64,
  parameter logic [XLEN-1:0] MSTATUS_RESET = 'h1800,
  parameter logic [XLEN-1:0] MTVEC_RESET   = '0,
  parameter logic [XLEN-1:0] VENDOR_ID     = 'h79737978,
  parameter logic [XLEN-1:0] ARCH_ID       = 'h016FBCBD
) (
  input  logic            clock,
  input  logic            reset,
  input  logic [XLEN-1:0] pc,
  input  logic [1:0]      csr_op,
  input  logic [11:0]     csr_addr,
  input  logic [XLEN-1:0] csr_wdata,
  input  logic            ecall_flag,
  input  logic            mret_flag,
  input  logic            instr_retire,
  output logic [XLEN-1:0] csr_rdata,
  output logic            illegal,
  output logic            trap_redirect,
  output logic [XLEN-1:0] trap_target,
  output logic [XLEN-1:0] mepc_out,
  output logic [XLEN-1:0] mtvec_out,
  output logic [XLEN-1:0] mstatus_out
);

  localparam bit              HAS_HI     = (CNT_WIDTH > XLEN);
  localparam logic [XLEN-1:0] ALIGN_MASK = ~XLEN'(3);

  logic [XLEN-1:0]      mstatus_reg, mtvec_reg, mscratch_reg, mepc_reg, mcause_reg;
  logic [CNT_WIDTH-1:0] mcycle, minstret;
  logic [XLEN-1:0]      mcycle_hi, minstret_hi;
  logic [XLEN-1:0]      old_val, new_val;
  logic                 mapped, read_only, has_write, trap, wr_en;
  csr_op_e              op;

  assign op   = csr_op_e'(csr_op);
  assign trap = ecall_flag | mret_flag;

  generate
    if (HAS_HI) begin : g_hi
      assign mcycle_hi   = mcycle[CNT_WIDTH-1:XLEN];
      assign minstret_hi = minstret[CNT_WIDTH-1:XLEN];
    end else begin : g_no_hi
      assign mcycle_hi   = '0;
      assign minstret_hi = '0;
    end
  endgenerate

  always_comb begin
    old_val   = '0;
    mapped    = 1'b1;
    read_only = 1'b0;
    case (csr_addr)
      ADDR_MSTATUS:   old_val = mstatus_reg;
      ADDR_MISA:      begin old_val = XLEN'(MISA_RV32I); read_only = 1'b1; end
      ADDR_MTVEC:     old_val = mtvec_reg;
      ADDR_MSCRATCH:  old_val = mscratch_reg;
      ADDR_MEPC:      old_val = mepc_reg;
      ADDR_MCAUSE:    old_val = mcause_reg;
      ADDR_MCYCLE:    old_val = mcycle[XLEN-1:0];
      ADDR_MINSTRET:  old_val = minstret[XLEN-1:0];
      ADDR_MCYCLEH:   if (HAS_HI) old_val = mcycle_hi; else mapped = 1'b0;
      ADDR_MINSTRETH: if (HAS_HI) old_val = minstret_hi; else mapped = 1'b0;
      ADDR_MVENDORID: begin old_val = VENDOR_ID; read_only = 1'b1; end
      ADDR_MARCHID:   begin old_val = ARCH_ID; read_only = 1'b1; end
      default:        mapped = 1'b0;
    endcase
  end

  always_comb begin
    new_val = old_val;
    case (op)
      CSR_RW:  new_val = csr_wdata;
      CSR_RS:  new_val = old_val | csr_wdata;
      CSR_RC:  new_val = old_val & ~csr_wdata;
      default: new_val = old_val;
    endcase
  end

  // Set/clear with a zero mask is a pure read, so it may target read-only CSRs.
  assign has_write = (op == CSR_RW) || ((op != CSR_NONE) && (csr_wdata != '0));
  assign illegal   = (op != CSR_NONE) && !trap && (!mapped || (read_only && has_write));
  assign wr_en     = has_write && mapped && !read_only && !trap;

  always_ff @(posedge clock) begin
    if (reset) begin
      mstatus_reg  <= MSTATUS_RESET;
      mtvec_reg    <= MTVEC_RESET;
      mscratch_reg <= '0;
      mepc_reg     <= '0;
      mcause_reg   <= '0;
    end else if (ecall_flag) begin
      mepc_reg                                  <= pc & ALIGN_MASK;
      mcause_reg                                <= XLEN'(MCAUSE_ECALL_M);
      mstatus_reg[MSTATUS_MPIE]                 <= mstatus_reg[MSTATUS_MIE];
      mstatus_reg[MSTATUS_MIE]                  <= 1'b0;
      mstatus_reg[MSTATUS_MPP_HI:MSTATUS_MPP_LO] <= 2'b11;
    end else if (mret_flag) begin
      mstatus_reg[MSTATUS_MIE]                  <= mstatus_reg[MSTATUS_MPIE];
      mstatus_reg[MSTATUS_MPIE]                 <= 1'b1;
      mstatus_reg[MSTATUS_MPP_HI:MSTATUS_MPP_LO] <= 2'b11;
    end else if (wr_en) begin
      case (csr_addr)
        ADDR_MSTATUS:  mstatus_reg  <= new_val;
        ADDR_MTVEC:    mtvec_reg    <= new_val & ALIGN_MASK;
        ADDR_MSCRATCH: mscratch_reg <= new_val;
        ADDR_MEPC:     mepc_reg     <= new_val & ALIGN_MASK;
        ADDR_MCAUSE:   mcause_reg   <= new_val;
        default:       ;
      endcase
    end
  end

  csr_counter #(.XLEN(XLEN), .CNT_WIDTH(CNT_WIDTH)) u_mcycle (
    .clock (clock),
    .reset (reset),
    .inc   (1'b1),
    .wr_lo (wr_en && (csr_addr == ADDR_MCYCLE)),
    .wr_hi (wr_en && (csr_addr == ADDR_MCYCLEH)),
    .wdata (new_val),
    .value (mcycle)
  );

  csr_counter #(.XLEN(XLEN), .CNT_WIDTH(CNT_WIDTH)) u_minstret (
    .clock (clock),
    .reset (reset),
    .inc   (instr_retire),
    .wr_lo (wr_en && (csr_addr == ADDR_MINSTRET)),
    .wr_hi (wr_en && (csr_addr == ADDR_MINSTRETH)),
    .wdata (new_val),
    .value (minstret)
  );

  assign csr_rdata     = old_val;
  assign trap_redirect = trap;
  assign trap_target   = ecall_flag ? mtvec_reg : (mret_flag ? mepc_reg : '0);
  assign mepc_out      = mepc_reg;
  assign mtvec_out     = mtvec_reg;
  assign mstatus_out   = mstatus_reg;

endmodule

// File: tb/tb_csr_machine_file.sv
// Randomised and directed bench for csr_machine_file against an architectural
// model of the CSR state (plain registers and 64-bit counters).
module tb_csr_machine_file;

  localparam logic [1:0]  OP_NONE = 2'd0, OP_RW = 2'd1, OP_RS = 2'd2, OP_RC = 2'd3;
  localparam logic [31:0] VENDOR  = 32'h79737978;
  localparam logic [31:0] ARCH    = 32'h016FBCBD;

  logic        clock = 1'b0;
  logic        reset;
  logic [31:0] pc;
  logic [1:0]  csr_op;
  logic [11:0] csr_addr;
  logic [31:0] csr_wdata;
  logic        ecall_flag, mret_flag, instr_retire;
  logic [31:0] csr_rdata, trap_target, mepc_out, mtvec_out, mstatus_out;
  logic        illegal, trap_redirect;

  int checks = 0;
  int errors = 0;

  logic [31:0] m_mstatus, m_mtvec, m_mscratch, m_mepc, m_mcause;
  logic [63:0] m_cyc, m_ret;

  csr_machine_file dut (
    .clock(clock), .reset(reset), .pc(pc), .csr_op(csr_op), .csr_addr(csr_addr),
    .csr_wdata(csr_wdata), .ecall_flag(ecall_flag), .mret_flag(mret_flag),
    .instr_retire(instr_retire), .csr_rdata(csr_rdata), .illegal(illegal),
    .trap_redirect(trap_redirect), .trap_target(trap_target), .mepc_out(mepc_out),
    .mtvec_out(mtvec_out), .mstatus_out(mstatus_out)
  );

  always #5 clock = ~clock;

  function automatic void ref_lookup(input logic [11:0] a, output bit mp, output bit ro,
                                     output logic [31:0] v);
    mp = 1'b1; ro = 1'b0; v = '0;
    case (a)
      12'h300: v = m_mstatus;
      12'h301: begin v = 32'h4000_0100; ro = 1'b1; end
      12'h305: v = m_mtvec;
      12'h340: v = m_mscratch;
      12'h341: v = m_mepc;
      12'h342: v = m_mcause;
      12'hB00: v = m_cyc[31:0];
      12'hB80: v = m_cyc[63:32];
      12'hB02: v = m_ret[31:0];
      12'hB82: v = m_ret[63:32];
      12'hF11: begin v = VENDOR; ro = 1'b1; end
      12'hF12: begin v = ARCH; ro = 1'b1; end
      default: mp = 1'b0;
    endcase
  endfunction

  // Expected combinational outputs for the inputs currently applied.
  function automatic void ref_comb(output logic [31:0] rd, output logic ill, output logic [31:0] tgt);
    bit mp, ro, wr;
    logic [31:0] v;
    ref_lookup(csr_addr, mp, ro, v);
    wr  = (csr_op == OP_RW) || (csr_op != OP_NONE && csr_wdata != 0);
    rd  = mp ? v : 32'h0;
    ill = (csr_op != OP_NONE) && !(ecall_flag || mret_flag) && (!mp || (ro && wr));
    tgt = ecall_flag ? m_mtvec : (mret_flag ? m_mepc : 32'h0);
  endfunction

  task automatic drive(input logic [1:0] op, input logic [11:0] a, input logic [31:0] wd,
                       input logic ec, input logic mr, input logic rt);
    csr_op = op; csr_addr = a; csr_wdata = wd;
    ecall_flag = ec; mret_flag = mr; instr_retire = rt;
    #1;
  endtask

  // Advance one clock edge, updating the model from the inputs held across it.
  task automatic step();
    logic [31:0] n_st, n_tv, n_sc, n_ep, n_ca, v, nv;
    logic [63:0] n_cyc, n_ret;
    bit mp, ro;
    n_st = m_mstatus; n_tv = m_mtvec; n_sc = m_mscratch; n_ep = m_mepc; n_ca = m_mcause;
    n_cyc = m_cyc + 64'd1;
    n_ret = m_ret + (instr_retire ? 64'd1 : 64'd0);
    if (reset) begin
      n_st = 32'h1800; n_tv = 0; n_sc = 0; n_ep = 0; n_ca = 0; n_cyc = 0; n_ret = 0;
    end else if (ecall_flag) begin
      n_ep = {pc[31:2], 2'b00}; n_ca = 11;
      n_st[7] = m_mstatus[3]; n_st[3] = 1'b0; n_st[12:11] = 2'b11;
    end else if (mret_flag) begin
      n_st[3] = m_mstatus[7]; n_st[7] = 1'b1; n_st[12:11] = 2'b11;
    end else if (csr_op != OP_NONE) begin
      ref_lookup(csr_addr, mp, ro, v);
      nv = (csr_op == OP_RW) ? csr_wdata : (csr_op == OP_RS) ? (v | csr_wdata) : (v & ~csr_wdata);
      if (mp && !ro && (csr_op == OP_RW || csr_wdata != 0)) begin
        case (csr_addr)
          12'h300: n_st = nv;
          12'h305: n_tv = {nv[31:2], 2'b00};
          12'h340: n_sc = nv;
          12'h341: n_ep = {nv[31:2], 2'b00};
          12'h342: n_ca = nv;
          12'hB00: n_cyc = {m_cyc[63:32], nv};
          12'hB80: n_cyc = {nv, m_cyc[31:0]};
          12'hB02: n_ret = {m_ret[63:32], nv};
          12'hB82: n_ret = {nv, m_ret[31:0]};
          default: ;
        endcase
      end
    end
    @(posedge clock);
    m_mstatus = n_st; m_mtvec = n_tv; m_mscratch = n_sc; m_mepc = n_ep; m_mcause = n_ca;
    m_cyc = n_cyc; m_ret = n_ret;
    @(negedge clock);
  endtask

  task automatic test_reset();
    reset = 1'b1; pc = 0;
    drive(OP_NONE, 12'h0, 0, 0, 0, 0);
    step(); step();
    reset = 1'b0;
    drive(OP_RS, 12'hB00, 0, 0, 0, 0);
    checks++;
    if (mstatus_out !== 32'h1800) begin errors++; $display("FAIL reset_mstatus got=%h exp=%h", mstatus_out, 32'h1800); end
    checks++;
    if (mtvec_out !== 32'h0) begin errors++; $display("FAIL reset_mtvec got=%h exp=0", mtvec_out); end
    checks++;
    if (mepc_out !== 32'h0) begin errors++; $display("FAIL reset_mepc got=%h exp=0", mepc_out); end
    checks++;
    if (csr_rdata !== 32'h0 || illegal !== 1'b0) begin
      errors++; $display("FAIL reset_mcycle got=%h ill=%b exp=0 ill=0", csr_rdata, illegal);
    end
    $display("txn reset: mstatus=%h mtvec=%h mepc=%h mcycle=%h", mstatus_out, mtvec_out, mepc_out, csr_rdata);
  endtask

  task automatic test_reset_mid();
    drive(OP_RW, 12'h340, 32'h55, 0, 0, 0); step();
    reset = 1'b1;
    drive(OP_RW, 12'h340, 32'hAA, 0, 0, 1); step();
    reset = 1'b0;
    drive(OP_RS, 12'h340, 0, 0, 0, 0);
    checks++;
    if (csr_rdata !== 32'h0 || mstatus_out !== 32'h1800) begin
      errors++; $display("FAIL reset_mid got=%h mstatus=%h exp=0 mstatus=1800", csr_rdata, mstatus_out);
    end
    $display("txn reset_mid: mscratch=%h", csr_rdata);
  endtask

  task automatic test_csr_rw();
    drive(OP_RW, 12'h305, 32'h80000107, 0, 0, 0); step();
    drive(OP_RS, 12'h305, 0, 0, 0, 0);
    checks++;
    if (csr_rdata !== 32'h80000104 || mtvec_out !== 32'h80000104) begin
      errors++; $display("FAIL rw_mtvec got=%h out=%h exp=80000104", csr_rdata, mtvec_out);
    end
    drive(OP_RS, 12'h300, 32'h8, 0, 0, 0); step();
    drive(OP_NONE, 12'h300, 0, 0, 0, 0);
    checks++;
    if (mstatus_out !== 32'h1808) begin errors++; $display("FAIL rs_mie got=%h exp=1808", mstatus_out); end
    drive(OP_RC, 12'h300, 32'h8, 0, 0, 0); step();
    drive(OP_NONE, 12'h300, 0, 0, 0, 0);
    checks++;
    if (mstatus_out !== 32'h1800) begin errors++; $display("FAIL rc_mie got=%h exp=1800", mstatus_out); end
    $display("txn csr_rw: mtvec=%h mstatus=%h", mtvec_out, mstatus_out);
  endtask

  task automatic test_trap();
    drive(OP_RS, 12'h300, 32'h8, 0, 0, 0); step();
    pc = 32'h1000;
    drive(OP_NONE, 12'h0, 0, 1, 0, 0);
    checks++;
    if (trap_redirect !== 1'b1 || trap_target !== m_mtvec) begin
      errors++; $display("FAIL ecall_target got=%b/%h exp=1/%h", trap_redirect, trap_target, m_mtvec);
    end
    step();
    drive(OP_RS, 12'h342, 0, 0, 0, 0);
    checks++;
    if (mepc_out !== 32'h1000 || csr_rdata !== 32'd11 || mstatus_out !== 32'h1880) begin
      errors++; $display("FAIL ecall_state got mepc=%h mcause=%h mstatus=%h exp 1000/b/1880", mepc_out, csr_rdata, mstatus_out);
    end
    drive(OP_NONE, 12'h0, 0, 0, 1, 0);
    checks++;
    if (trap_redirect !== 1'b1 || trap_target !== 32'h1000) begin
      errors++; $display("FAIL mret_target got=%b/%h exp=1/1000", trap_redirect, trap_target);
    end
    step();
    drive(OP_NONE, 12'h0, 0, 0, 0, 0);
    checks++;
    if (mstatus_out !== 32'h1888 || trap_redirect !== 1'b0) begin
      errors++; $display("FAIL mret_state got=%h redir=%b exp=1888 redir=0", mstatus_out, trap_redirect);
    end
    $display("txn trap: mepc=%h mstatus=%h", mepc_out, mstatus_out);
  endtask

  task automatic test_illegal();
    pc = 32'h2000;
    drive(OP_RW, 12'h341, 32'hDEAD, 1, 0, 0);
    checks++;
    if (illegal !== 1'b0) begin errors++; $display("FAIL drop_illegal got=%b exp=0", illegal); end
    step();
    drive(OP_NONE, 12'h0, 0, 0, 0, 0);
    checks++;
    if (mepc_out !== 32'h2000) begin errors++; $display("FAIL drop_mepc got=%h exp=2000", mepc_out); end
    drive(OP_RW, 12'hF11, 32'h1234, 0, 0, 0);
    checks++;
    if (illegal !== 1'b1) begin errors++; $display("FAIL ro_write got=%b exp=1", illegal); end
    step();
    drive(OP_RS, 12'hF11, 0, 0, 0, 0);
    checks++;
    if (csr_rdata !== VENDOR || illegal !== 1'b0) begin
      errors++; $display("FAIL ro_read got=%h ill=%b exp=%h ill=0", csr_rdata, illegal, VENDOR);
    end
    drive(OP_RS, 12'h7C0, 0, 0, 0, 0);
    checks++;
    if (csr_rdata !== 32'h0 || illegal !== 1'b1) begin
      errors++; $display("FAIL unmapped got=%h ill=%b exp=0 ill=1", csr_rdata, illegal);
    end
    checks++;
    if (mstatus_out !== m_mstatus || mepc_out !== m_mepc || mtvec_out !== m_mtvec) begin
      errors++; $display("FAIL illegal_unchanged got=%h/%h/%h exp=%h/%h/%h",
                         mstatus_out, mepc_out, mtvec_out, m_mstatus, m_mepc, m_mtvec);
    end
    $display("txn illegal: vendor=%h", VENDOR);
  endtask

  task automatic test_counters();
    drive(OP_RW, 12'hB00, 32'hFFFFFFFF, 0, 0, 0); step();
    drive(OP_RW, 12'hB80, 32'hFFFFFFFF, 0, 0, 0); step();
    drive(OP_RS, 12'hB80, 0, 0, 0, 0);
    checks++;
    if (csr_rdata !== 32'hFFFFFFFF) begin errors++; $display("FAIL mcycle_hi_wr got=%h exp=ffffffff", csr_rdata); end
    step();
    drive(OP_RS, 12'hB00, 0, 0, 0, 0);
    checks++;
    if (csr_rdata !== 32'h0 || m_cyc !== 64'h0) begin errors++; $display("FAIL mcycle_wrap got=%h exp=0", csr_rdata); end
    drive(OP_RS, 12'hB80, 0, 0, 0, 0);
    checks++;
    if (csr_rdata !== 32'h0) begin errors++; $display("FAIL mcycle_wrap_hi got=%h exp=0", csr_rdata); end
    drive(OP_RW, 12'hB02, 0, 0, 0, 0); step();
    drive(OP_RW, 12'hB82, 0, 0, 0, 0); step();
    for (int i = 0; i < 10; i++) begin
      drive(OP_NONE, 12'h0, 0, 0, 0, 1); step();
    end
    drive(OP_RS, 12'hB02, 0, 0, 0, 0);
    checks++;
    if (csr_rdata !== 32'd10) begin errors++; $display("FAIL minstret_10 got=%0d exp=10", csr_rdata); end
    drive(OP_RW, 12'hB02, 32'd5, 0, 0, 1); step();
    drive(OP_RS, 12'hB02, 0, 0, 0, 0);
    checks++;
    if (csr_rdata !== 32'd5) begin errors++; $display("FAIL minstret_write_wins got=%0d exp=5", csr_rdata); end
    $display("txn counters: minstret=%0d", csr_rdata);
  endtask

  task automatic test_random();
    logic [11:0] addrs [13] = '{12'h300, 12'h301, 12'h305, 12'h340, 12'h341, 12'h342,
                                12'hB00, 12'hB80, 12'hB02, 12'hB82, 12'hF11, 12'hF12, 12'h7C0};
    logic [31:0] e_rd, e_tgt, wd;
    logic        e_ill;
    for (int n = 0; n < 400; n++) begin
      reset = ($urandom_range(0, 63) == 0);
      pc    = $urandom & 32'hFFFF_FFFC;
      wd    = ($urandom_range(0, 3) == 0) ? 32'h0 : $urandom;
      drive(2'($urandom_range(0, 3)), addrs[$urandom_range(0, 12)], wd,
            ($urandom_range(0, 15) == 0), ($urandom_range(0, 15) == 0), 1'($urandom_range(0, 1)));
      ref_comb(e_rd, e_ill, e_tgt);
      checks++;
      if (csr_rdata !== e_rd || illegal !== e_ill) begin
        errors++; $display("FAIL rand_read n=%0d addr=%h got=%h/%b exp=%h/%b", n, csr_addr, csr_rdata, illegal, e_rd, e_ill);
      end
      checks++;
      if (trap_redirect !== (ecall_flag | mret_flag) || trap_target !== e_tgt) begin
        errors++; $display("FAIL rand_trap n=%0d got=%b/%h exp=%b/%h", n, trap_redirect, trap_target, ecall_flag | mret_flag, e_tgt);
      end
      checks++;
      if (mstatus_out !== m_mstatus || mtvec_out !== m_mtvec || mepc_out !== m_mepc) begin
        errors++; $display("FAIL rand_regs n=%0d got=%h/%h/%h exp=%h/%h/%h", n,
                           mstatus_out, mtvec_out, mepc_out, m_mstatus, m_mtvec, m_mepc);
      end
      $display("txn %0d rst=%b op=%0d addr=%h wdata=%h ec=%b mr=%b rdata=%h ill=%b",
               n, reset, csr_op, csr_addr, csr_wdata, ecall_flag, mret_flag, csr_rdata, illegal);
      step();
    end
    reset = 1'b0;
  endtask

  initial begin
    test_reset();
    test_csr_rw();
    test_trap();
    test_illegal();
    test_counters();
    test_reset_mid();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
